// File: rtl/alu_seq_exec.sv
// EX-stage ALU: decodes ALUOp/Funct, executes, returns a registered result over valid/ready.
// MUL and DIV/REM iterate XLEN cycles; define ALU_FAST_MUL_EN for a single-cycle multiplier.
module alu_seq_exec #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [1:0]      ALUOp_i,
  input  logic [9:0]      Funct_i,
  input  logic [XLEN-1:0] Op1_i,
  input  logic [XLEN-1:0] Op2_i,
  input  logic            Valid_i,
  output logic            Ready_o,
  output logic [XLEN-1:0] Result_o,
  output logic            Valid_o,
  input  logic            Ready_i,
  output logic            IllegalOp_o
);

  localparam logic [1:0] ALU_OP_REG = 2'b00;
  localparam logic [1:0] ALU_OP_IMM = 2'b01;
  localparam logic [1:0] ALU_OP_STR = 2'b10;

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL, OP_SRA,
    OP_SLT, OP_SLTU, OP_MUL, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } alu_ctl_t;

  state_t          r_state, w_state_nxt, w_launch_state;
  alu_ctl_t        w_ctl;
  logic [6:0]      w_f7;
  logic [2:0]      w_f3;
  logic [SHW-1:0]  w_shamt;
  logic [XLEN-1:0] w_single, w_launch_result;
  logic            w_accept, w_is_mul_iter, w_is_div, w_div_signed, w_div_rem;
  logic            w_div_zero, w_div_ovf, w_div_special;
  logic            w_op1_neg, w_op2_neg;
  logic [XLEN-1:0] w_op1_mag, w_op2_mag, w_special_res;

  logic [XLEN-1:0] r_result, r_acc, r_opa, r_opb;
  logic [CW-1:0]   r_cnt;
  logic            r_illegal, r_neg_q, r_neg_r, r_sel_rem;

  assign w_f7    = Funct_i[9:3];
  assign w_f3    = Funct_i[2:0];
  assign w_shamt = Op2_i[SHW-1:0];

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_ctl = OP_ILL;
    case (ALUOp_i)
      ALU_OP_REG: begin
        if (w_f7 == 7'b0000000) begin
          case (w_f3)
            3'b000:  w_ctl = OP_ADD;
            3'b001:  w_ctl = OP_SLL;
            3'b010:  w_ctl = OP_SLT;
            3'b011:  w_ctl = OP_SLTU;
            3'b100:  w_ctl = OP_XOR;
            3'b101:  w_ctl = OP_SRL;
            3'b110:  w_ctl = OP_OR;
            default: w_ctl = OP_AND;
          endcase
        end else if (w_f7 == 7'b0100000) begin
          if (w_f3 == 3'b000)      w_ctl = OP_SUB;
          else if (w_f3 == 3'b101) w_ctl = OP_SRA;
        end else if (w_f7 == 7'b0000001) begin
          case (w_f3)
            3'b000:  w_ctl = OP_MUL;
            3'b100:  w_ctl = OP_DIV;
            3'b101:  w_ctl = OP_DIVU;
            3'b110:  w_ctl = OP_REM;
            3'b111:  w_ctl = OP_REMU;
            default: w_ctl = OP_ILL;
          endcase
        end
      end
      ALU_OP_IMM: begin
        case (w_f3)
          3'b000:  w_ctl = OP_ADD;
          3'b001:  w_ctl = OP_SLL;
          3'b010:  w_ctl = OP_SLT;
          3'b011:  w_ctl = OP_SLTU;
          3'b100:  w_ctl = OP_XOR;
          3'b101:  w_ctl = Funct_i[8] ? OP_SRA : OP_SRL;
          3'b110:  w_ctl = OP_OR;
          default: w_ctl = OP_AND;
        endcase
      end
      ALU_OP_STR: if (w_f3 <= 3'b010) w_ctl = OP_ADD;
      default:    w_ctl = OP_ILL;
    endcase
  end

  always_comb begin
    w_single = '0;
    case (w_ctl)
      OP_ADD:  w_single = Op1_i + Op2_i;
      OP_SUB:  w_single = Op1_i - Op2_i;
      OP_AND:  w_single = Op1_i & Op2_i;
      OP_OR:   w_single = Op1_i | Op2_i;
      OP_XOR:  w_single = Op1_i ^ Op2_i;
      OP_SLL:  w_single = Op1_i << w_shamt;
      OP_SRL:  w_single = Op1_i >> w_shamt;
      OP_SRA:  w_single = $signed(Op1_i) >>> w_shamt;
      OP_SLT:  w_single = {{(XLEN-1){1'b0}}, $signed(Op1_i) < $signed(Op2_i)};
      OP_SLTU: w_single = {{(XLEN-1){1'b0}}, Op1_i < Op2_i};
`ifdef ALU_FAST_MUL_EN
      OP_MUL:  w_single = Op1_i * Op2_i;
`endif
      default: w_single = '0;
    endcase
  end

`ifdef ALU_FAST_MUL_EN
  assign w_is_mul_iter = 1'b0;
`else
  assign w_is_mul_iter = (w_ctl == OP_MUL);
`endif

  assign w_is_div      = (w_ctl == OP_DIV) || (w_ctl == OP_DIVU) || (w_ctl == OP_REM) || (w_ctl == OP_REMU);
  assign w_div_signed  = (w_ctl == OP_DIV) || (w_ctl == OP_REM);
  assign w_div_rem     = (w_ctl == OP_REM) || (w_ctl == OP_REMU);
  assign w_div_zero    = (Op2_i == '0);
  assign w_div_ovf     = w_div_signed && (Op1_i == {1'b1, {(XLEN-1){1'b0}}}) && (Op2_i == '1);
  assign w_div_special = w_div_zero || w_div_ovf;
  assign w_special_res = w_div_zero ? (w_div_rem ? Op1_i : '1) : (w_div_rem ? '0 : Op1_i);

  assign w_op1_neg = w_div_signed & Op1_i[XLEN-1];
  assign w_op2_neg = w_div_signed & Op2_i[XLEN-1];
  assign w_op1_mag = w_op1_neg ? -Op1_i : Op1_i;
  assign w_op2_mag = w_op2_neg ? -Op2_i : Op2_i;

  assign w_launch_result = w_is_div ? w_special_res : w_single;
  assign w_launch_state  = w_is_mul_iter ? ST_MUL :
                           (w_is_div && !w_div_special) ? ST_DIV : ST_DONE;

  // One shift-add step: r_opa is the multiplier shifting right, r_opb the multiplicand shifting left.
  logic [XLEN-1:0] w_mul_acc_nxt;
  assign w_mul_acc_nxt = r_acc + (r_opa[0] ? r_opb : '0);

  // One restoring step: r_acc is the partial remainder, r_opa the dividend turning into the quotient.
  logic [XLEN:0]   w_div_trial;
  logic            w_div_ge;
  logic [XLEN-1:0] w_rem_nxt, w_quo_nxt, w_quo_fix, w_rem_fix;
  assign w_div_trial = {r_acc, r_opa[XLEN-1]} - {1'b0, r_opb};
  assign w_div_ge    = ~w_div_trial[XLEN];
  assign w_rem_nxt   = w_div_ge ? w_div_trial[XLEN-1:0] : {r_acc[XLEN-2:0], r_opa[XLEN-1]};
  assign w_quo_nxt   = {r_opa[XLEN-2:0], w_div_ge};
  assign w_quo_fix   = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_rem_fix   = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  assign w_accept = Valid_i && Ready_o;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    Ready_o     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        Ready_o = 1'b1;
        if (Valid_i) w_state_nxt = w_launch_state;
      end
      ST_MUL, ST_DIV: if (r_cnt == CNT_LAST) w_state_nxt = ST_DONE;
      default: begin
        Ready_o = Ready_i;
        if (Ready_i) w_state_nxt = Valid_i ? w_launch_state : ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
  // NOTE: datapath registers are reset too, so Result_o reads 0 out of reset and after an aborted op.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_result  <= '0;
      r_illegal <= 1'b0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_cnt     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_sel_rem <= 1'b0;
    end else if (w_accept) begin
      r_illegal <= (w_ctl == OP_ILL);
      r_cnt     <= '0;
      r_acc     <= '0;
      r_neg_q   <= w_op1_neg ^ w_op2_neg;
      r_neg_r   <= w_op1_neg;
      r_sel_rem <= w_div_rem;
      if (w_launch_state == ST_MUL) begin
        r_opa <= Op2_i;
        r_opb <= Op1_i;
      end else begin
        r_opa <= w_op1_mag;
        r_opb <= w_op2_mag;
      end
      if (w_launch_state == ST_DONE) r_result <= w_launch_result;
    end else if (r_state == ST_MUL) begin
      r_acc <= w_mul_acc_nxt;
      r_opa <= r_opa >> 1;
      r_opb <= r_opb << 1;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CNT_LAST) r_result <= w_mul_acc_nxt;
    end else if (r_state == ST_DIV) begin
      r_acc <= w_rem_nxt;
      r_opa <= w_quo_nxt;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == CNT_LAST) r_result <= r_sel_rem ? w_rem_fix : w_quo_fix;
    end
  end

  assign Result_o    = r_result;
  assign IllegalOp_o = r_illegal;
  assign Valid_o     = (r_state == ST_DONE);

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec (XLEN=32): directed scenarios plus randomized ops
// checked against an arithmetic reference model. Honours ALU_FAST_MUL_EN for MUL latency.
module tb_alu_seq_exec;

  localparam int XLEN = 32;
  localparam logic [1:0] ALU_OP_REG = 2'b00;
  localparam logic [1:0] ALU_OP_IMM = 2'b01;
  localparam logic [1:0] ALU_OP_STR = 2'b10;
`ifdef ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b0;
  logic [1:0]      ALUOp_i = '0;
  logic [9:0]      Funct_i = '0;
  logic [XLEN-1:0] Op1_i = '0, Op2_i = '0;
  logic            Valid_i = 1'b0, Ready_i = 1'b1;
  logic            Ready_o, Valid_o, IllegalOp_o;
  logic [XLEN-1:0] Result_o;

  int checks = 0;
  int errors = 0;

  alu_seq_exec #(.XLEN(XLEN)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ALUOp_i(ALUOp_i), .Funct_i(Funct_i),
    .Op1_i(Op1_i), .Op2_i(Op2_i), .Valid_i(Valid_i), .Ready_o(Ready_o),
    .Result_o(Result_o), .Valid_o(Valid_o), .Ready_i(Ready_i), .IllegalOp_o(IllegalOp_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: results straight from ISA arithmetic, latency from the op class.
  function automatic void model(input logic [1:0] op, input logic [9:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    logic [6:0] f7;
    logic [2:0] f3;
    logic signed [31:0] sa, sb;
    int sh;
    logic sgn, rem;
    f7 = fn[9:3]; f3 = fn[2:0]; sa = a; sb = b; sh = int'(b[4:0]);
    r = '0; ill = 1'b0; lat = 1;
    if (op == ALU_OP_STR) begin
      if (f3 <= 3'd2) r = a + b; else ill = 1'b1;
    end else if (op == ALU_OP_IMM || (op == ALU_OP_REG && f7 == 7'h00)) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << sh;
        3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = (op == ALU_OP_IMM && fn[8]) ? 32'(sa >>> sh) : a >> sh;
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (op == ALU_OP_REG && f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) begin
      r = (f3 == 3'd0) ? a - b : 32'(sa >>> sh);
    end else if (op == ALU_OP_REG && f7 == 7'h01 && f3 == 3'd0) begin
      r = a * b; lat = MUL_LAT;
    end else if (op == ALU_OP_REG && f7 == 7'h01 && f3 >= 3'd4) begin
      sgn = (f3 == 3'd4 || f3 == 3'd6);
      rem = f3[1];
      if (b == 0) r = rem ? a : 32'hFFFF_FFFF;
      else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = rem ? 32'd0 : a;
      else begin
        lat = DIV_LAT;
        if (sgn) r = rem ? 32'(sa % sb) : 32'(sa / sb);
        else     r = rem ? a % b : a / b;
      end
    end else begin
      ill = 1'b1;
    end
    if (ill) r = '0;
  endfunction

  // Drives one request, waits (bounded) for accept and result; call at negedge+1.
  task automatic do_op(input logic [1:0] op, input logic [9:0] fn,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output logic ill, output int lat,
                       output logic busy_rdy);
    int guard;
    ALUOp_i = op; Funct_i = fn; Op1_i = a; Op2_i = b; Valid_i = 1'b1;
    busy_rdy = 1'b0; guard = 0;
    #1;
    while (!Ready_o && guard < 200) begin
      @(negedge clk_i); #1; guard++;
    end
    @(posedge clk_i);
    @(negedge clk_i);
    Valid_i = 1'b0; Op1_i = $urandom; Op2_i = $urandom; Funct_i = 10'($urandom);
    #1;
    lat = 1;
    while (!Valid_o && lat < 200) begin
      if (Ready_o) busy_rdy = 1'b1;
      @(negedge clk_i); #1; lat++;
    end
    res = Result_o; ill = IllegalOp_o;
  endtask

  task automatic idle_cycle();
    @(negedge clk_i); #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if (Valid_o !== 1'b0)     begin errors++; $display("FAIL reset_valid: got %b want 0", Valid_o); end
    checks++; if (Result_o !== '0)      begin errors++; $display("FAIL reset_result: got %h want 0", Result_o); end
    checks++; if (IllegalOp_o !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", IllegalOp_o); end
    checks++; if (Ready_o !== 1'b1)     begin errors++; $display("FAIL reset_ready: got %b want 1", Ready_o); end
    @(negedge clk_i); rst_i = 1'b1;
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    idle_cycle();
    Ready_i = 1'b1; ALUOp_i = ALU_OP_REG; Funct_i = {7'h00, 3'b000};
    Op1_i = 32'd5; Op2_i = 32'd7; Valid_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    Funct_i = {7'h20, 3'b000}; #1;
    checks++; if (Valid_o !== 1'b1)    begin errors++; $display("FAIL b2b_add_valid: got %b want 1", Valid_o); end
    checks++; if (Result_o !== 32'd12) begin errors++; $display("FAIL b2b_add: got %h want 0000000c", Result_o); end
    checks++; if (Ready_o !== 1'b1)    begin errors++; $display("FAIL b2b_ready: got %b want 1", Ready_o); end
    @(posedge clk_i); @(negedge clk_i);
    Valid_i = 1'b0; #1;
    checks++; if (Valid_o !== 1'b1)          begin errors++; $display("FAIL b2b_sub_valid: got %b want 1", Valid_o); end
    checks++; if (Result_o !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_sub: got %h want fffffffe", Result_o); end
    idle_cycle();
    checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid: got %b want 0", Valid_o); end
  endtask

  task automatic test_shifts();
    logic [31:0] res; logic ill, busy; int lat;
    idle_cycle();
    do_op(ALU_OP_IMM, {7'h20, 3'b101}, 32'h8000_0000, 32'd4, res, ill, lat, busy);
    checks++; if (res !== 32'hF800_0000) begin errors++; $display("FAIL srai: got %h want f8000000", res); end
    checks++; if (lat !== 1)             begin errors++; $display("FAIL srai_lat: got %0d want 1", lat); end
    do_op(ALU_OP_IMM, {7'h00, 3'b101}, 32'h8000_0000, 32'd4, res, ill, lat, busy);
    checks++; if (res !== 32'h0800_0000) begin errors++; $display("FAIL srli: got %h want 08000000", res); end
    do_op(ALU_OP_REG, {7'h20, 3'b101}, 32'h8000_0000, 32'hFFFF_FFE4, res, ill, lat, busy);
    checks++; if (res !== 32'hF800_0000) begin errors++; $display("FAIL sra_shamt_low5: got %h want f8000000", res); end
  endtask

  task automatic test_mul();
    logic [31:0] res; logic ill, busy; int lat;
    idle_cycle();
    do_op(ALU_OP_REG, {7'h01, 3'b000}, 32'hFFFF_FFFF, 32'd3, res, ill, lat, busy);
    checks++; if (res !== 32'hFFFF_FFFD) begin errors++; $display("FAIL mul: got %h want fffffffd", res); end
    checks++; if (lat !== MUL_LAT)       begin errors++; $display("FAIL mul_lat: got %0d want %0d", lat, MUL_LAT); end
    checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL mul_busy_ready: got %b want 0", busy); end
  endtask

  task automatic test_div();
    logic [1:0]  ops [5] = '{ALU_OP_REG, ALU_OP_REG, ALU_OP_REG, ALU_OP_REG, ALU_OP_REG};
    logic [2:0]  f3s [5] = '{3'b100, 3'b110, 3'b101, 3'b110, 3'b100};
    logic [31:0] as  [5] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exs [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000};
    int          lats[5] = '{DIV_LAT, DIV_LAT, 1, 1, 1};
    logic [31:0] res; logic ill, busy; int lat;
    idle_cycle();
    for (int i = 0; i < 5; i++) begin
      do_op(ops[i], {7'h01, f3s[i]}, as[i], bs[i], res, ill, lat, busy);
      checks++; if (res !== exs[i]) begin errors++; $display("FAIL div_case%0d: got %h want %h", i, res, exs[i]); end
      checks++; if (lat !== lats[i]) begin errors++; $display("FAIL div_lat%0d: got %0d want %0d", i, lat, lats[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] res, a, b; logic ill, busy; int lat;
    idle_cycle();
    a = $urandom; b = $urandom;
    Ready_i = 1'b0;
    do_op(ALU_OP_REG, {7'h00, 3'b100}, a, b, res, ill, lat, busy);
    checks++; if (res !== (a ^ b)) begin errors++; $display("FAIL bp_xor: got %h want %h", res, a ^ b); end
    for (int i = 0; i < 5; i++) begin
      idle_cycle();
      checks++; if (Valid_o !== 1'b1 || Result_o !== (a ^ b) || Ready_o !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: valid %b result %h ready %b want 1 %h 0", i, Valid_o, Result_o, Ready_o, a ^ b);
      end
    end
    Ready_i = 1'b1; #1;
    checks++; if (Ready_o !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", Ready_o); end
    idle_cycle();
    checks++; if (Valid_o !== 1'b0) begin errors++; $display("FAIL bp_handshake: got valid %b want 0", Valid_o); end
  endtask

  task automatic test_illegal();
    logic [31:0] res; logic ill, busy; int lat;
    idle_cycle();
    do_op(ALU_OP_REG, {7'h7F, 3'b000}, 32'd9, 32'd9, res, ill, lat, busy);
    checks++; if (ill !== 1'b1) begin errors++; $display("FAIL illegal_flag: got %b want 1", ill); end
    checks++; if (res !== '0)   begin errors++; $display("FAIL illegal_result: got %h want 0", res); end
    checks++; if (lat !== 1)    begin errors++; $display("FAIL illegal_lat: got %0d want 1", lat); end
    do_op(2'b11, {7'h00, 3'b000}, 32'd1, 32'd1, res, ill, lat, busy);
    checks++; if (ill !== 1'b1 || res !== '0) begin errors++; $display("FAIL illegal_aluop: got ill %b res %h want 1 0", ill, res); end
    do_op(ALU_OP_STR, {7'h00, 3'b010}, 32'd100, 32'd28, res, ill, lat, busy);
    checks++; if (ill !== 1'b0 || res !== 32'd128) begin errors++; $display("FAIL str_add: got ill %b res %h want 0 80", ill, res); end
  endtask

  task automatic test_reset_mid_div();
    logic [31:0] res; logic ill, busy; int lat, seen;
    idle_cycle();
    do_op(ALU_OP_REG, {7'h00, 3'b000}, 32'd5, 32'd7, res, ill, lat, busy);
    idle_cycle();
    ALUOp_i = ALU_OP_REG; Funct_i = {7'h01, 3'b100}; Op1_i = 32'hFFFF_FC18; Op2_i = 32'd7; Valid_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i); Valid_i = 1'b0;
    repeat (5) @(negedge clk_i);
    #1;
    checks++; if (Valid_o !== 1'b0 || Ready_o !== 1'b0) begin errors++; $display("FAIL div_busy: valid %b ready %b want 0 0", Valid_o, Ready_o); end
    rst_i = 1'b0; #1;
    checks++; if (Valid_o !== 1'b0 || Result_o !== '0 || IllegalOp_o !== 1'b0 || Ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_div: valid %b result %h ill %b ready %b want 0 0 0 1", Valid_o, Result_o, IllegalOp_o, Ready_o);
    end
    @(negedge clk_i); rst_i = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk_i); #1;
      if (Valid_o) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_spurious_valid: got %0d cycles want 0", seen); end
  endtask

  task automatic test_random();
    logic [31:0] res, a, b, er; logic ill, busy, eill; int lat, elat;
    logic [1:0] op; logic [6:0] f7; logic [2:0] f3;
    logic [31:0] specials [4] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h1};
    idle_cycle();
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(0, 3));
      f3 = 3'($urandom);
      case ($urandom_range(0, 3))
        0: f7 = 7'h00;
        1: f7 = 7'h20;
        2: f7 = 7'h01;
        default: f7 = 7'($urandom);
      endcase
      a = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      b = ($urandom_range(0, 4) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
      model(op, {f7, f3}, a, b, er, eill, elat);
      do_op(op, {f7, f3}, a, b, res, ill, lat, busy);
      checks++; if (res !== er) begin errors++; $display("FAIL rnd%0d_result op %0d f %h a %h b %h: got %h want %h", i, op, {f7, f3}, a, b, res, er); end
      checks++; if (ill !== eill) begin errors++; $display("FAIL rnd%0d_illegal: got %b want %b", i, ill, eill); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_shifts();
    test_mul();
    test_div();
    test_backpressure();
    test_illegal();
    test_random();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_seq_exec.md
Name: alu_seq_exec

Overview:
Parametrised successor to the combinational ALU control decoder. It decodes ALUOp/Funct into an internal ALU control code, executes the operation and returns a registered result over a valid/ready handshake. Single-cycle ops complete in one cycle; MUL and DIV/REM run iteratively, so the EX stage can stall on them. It sits in EX, between the ID/EX pipeline register and EX/MEM.

Parameters:
XLEN, 32, operand/result width (≥8, even).

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
ALUOp_i  in  2  ALU_OP_REG / ALU_OP_IMM / ALU_OP_STR (Const.v encodings); the 4th encoding is illegal
Funct_i  in  10  {funct7, funct3}
Op1_i  in  XLEN  rs1 value
Op2_i  in  XLEN  rs2 value or immediate
Valid_i  in  1  request valid
Ready_o  out  1  request accepted when Valid_i && Ready_o
Result_o  out  XLEN  result, registered
Valid_o  out  1  result valid
Ready_i  in  1  consumer accepts result
IllegalOp_o  out  1  qualifies Valid_o: undecodable request

Behaviour:
- Reset (rst_i low, async): state=IDLE; Valid_o=0; Result_o=0; IllegalOp_o=0; iteration counter and datapath registers = 0. Reset mid-iteration aborts the op; no result is produced.
- Decode, REG: funct3 111 and, 110 or, 100 xor, 001 sll, 101 srl (f7=0000000) or sra (f7=0100000), 000 add/sub (f7=0000000/0100000), 010 slt, 011 sltu.
- Decode, REG with f7=0000001: 000 mul (low XLEN bits), 100 div, 101 divu, 110 rem, 111 remu.
- Decode, IMM: 000 addi, 010 slti, 011 sltiu, 100 xori, 110 ori, 111 andi, 001 slli, 101 srli/srai (selected by Funct_i[8]).
- Decode, STR: funct3 000/001/010 -> add.
- Illegal: any other combination. The request completes in 1 cycle with Result_o=0 and IllegalOp_o=1.
- Shift amount = Op2_i[log2(XLEN)-1:0].
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE: Ready_o=1. Accept of a single-cycle or illegal op -> DONE with the result registered, so Valid_o rises the next cycle (latency 1).
  - IDLE, accept mul -> MUL. XLEN shift-add iterations on the low half only -> DONE. Latency XLEN+1.
  - IDLE, accept div/rem -> DIV. Restoring division, XLEN iterations, on magnitudes for signed ops; sign fix-up in the final iteration (quotient negative iff signs differ, remainder takes the dividend's sign) -> DONE. Latency XLEN+1.
  - DIV special cases resolve at accept, latency 1. Divisor 0: quotient all-ones, remainder = Op1. Signed overflow (Op1=-2^(XLEN-1), Op2=-1): quotient = Op1, remainder = 0.
  - DONE: Valid_o=1. Result_o and IllegalOp_o stay stable until Ready_i. Ready_o = Ready_i, so a new request accepted in the same cycle as the result handshake gives back-to-back single-cycle throughput. Ready_i=1 with no new request -> IDLE.
- Inputs are sampled only at accept. Operand changes during MUL/DIV have no effect.
- Valid_i with Ready_o=0 is held off; the requester keeps the request stable.

Optional Feature:
ALU_FAST_MUL_EN
- Defined: mul is single-cycle, using a combinational XLEN×XLEN multiplier with the low XLEN bits registered; latency 1; state MUL is unused/unreachable.
- Undefined: iterative MUL as specified, latency XLEN+1.
- DIV is iterative in both builds.

Test Plan:
1. XLEN=32. add 5+7, then sub 5-7 back-to-back with Ready_i=1 -> 12, then 0xFFFFFFFE. Valid_o in consecutive cycles; each op latency 1.
2. srai Op1=0x80000000, Op2=4 -> 0xF8000000. srli with the same operands -> 0x08000000.
3. mul 0xFFFFFFFF × 3 -> 0xFFFFFFFD. Valid_o exactly 33 cycles after accept and Ready_o=0 meanwhile; with ALU_FAST_MUL_EN, after 1 cycle.
4. div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 7/0 -> 0xFFFFFFFF; rem 0x80000000/-1 -> 0; div 0x80000000/-1 -> 0x80000000. The special cases (divide by zero, signed overflow) have latency 1.
5. Ready_i held 0 for 5 cycles in DONE -> Result_o/Valid_o stable, Ready_o=0. Ready_i=1 -> handshake completes.
6. ALUOp_i=ALU_OP_REG, Funct_i={7'b1111111,3'b000} -> IllegalOp_o=1 with Result_o=0. Also assert rst_i low mid-DIV -> outputs 0 and IDLE immediately; no spurious Valid_o after release.
